mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the CPU data-memory interface. Takes one load/store request at a time from the multi-cycle datapath and drives the byte-addressed, little-endian, word-wide memory port (MemRd, MemWr, address, W_data, R_data).
- Supports byte, halfword and word accesses. Loads are sign- or zero-extended.
- Sub-word stores use a read-modify-write sequence, because the memory always writes all 4 bytes.

Parameters:
- DATA_W, 32, data word width; fixed at 32, memory lanes assume 4 bytes.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- busy  out  1  high from the cycle after acceptance until ack.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  load result; held until the next load completes.
- err  out  1  misalignment flag (MISALIGN_TRAP_EN only; tied 0 otherwise).
- MemRd  out  1  memory read enable.
- MemWr  out  1  memory write enable.
- Addr  out  ADDR_W  memory address, always word-aligned (low 2 bits 00).
- W_data  out  DATA_W  memory write data.
- R_data  in  DATA_W  memory read data; combinational, valid in the same cycle MemRd is high.

Behaviour:
- Reset: state IDLE; busy, ack, err, MemRd and MemWr all 0; Addr, W_data and rdata all 0.
- Reset mid-operation: state returns to IDLE at that edge and MemRd/MemWr are low the following cycle. No ack is issued. A partial memory write is tolerated.
- States: IDLE, RD, RMW_RD, WR, DONE.
- Request capture: in IDLE with req=1, addr, size, we, signed and wdata are latched.
- Transitions out of IDLE:
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RMW_RD.
- RD: MemRd=1, Addr = {addr[ADDR_W-1:2], 2'b00}. At the end of the cycle, R_data is lane-extracted and extended into rdata. → DONE.
- RMW_RD: MemRd=1 at the aligned address. R_data is captured into the merge register. → WR.
- WR: MemWr=1 for exactly one cycle, at the aligned address. W_data is:
  - the merged word for sub-word stores;
  - req_wdata unchanged for word stores.
  → DONE.
- DONE: ack=1 for one cycle, busy=0. → IDLE.
- Latency from the accepting edge to ack: load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
- MemRd and MemWr are never high in the same cycle.
- req while not in IDLE is ignored; no queuing.
- Byte lanes: lane k = bits [8k+7:8k] and sits at byte address addr+k.
- Byte access uses lane addr[1:0]. Half access uses lanes {2·addr[1]+1, 2·addr[1]}.
- Store merge: only the selected lane(s) are replaced with req_wdata[7:0] or req_wdata[15:0]; all other lanes keep the read value.
- Without MISALIGN_TRAP_EN, address bits that break alignment are ignored:
  - half: addr[0] is dropped;
  - word: addr[1:0] are dropped.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, goes IDLE → DONE directly.
  - No MemRd or MemWr is issued.
  - ack=1 and err=1 together for one cycle; rdata is unchanged.
- Not defined: err is tied to 0 and misaligned addresses are silently aligned down.

Decomposition:
- Shared package/header holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encodings;
  - the WIDTH macro already used by the datapath.
- One combinational sub-module, mem_lane_align, does both lane extraction with sign/zero extension (loads) and lane merge (stores). The FSM stays in mem_access_ctrl.

Test Plan:
- Memory word at 0x10 = 0x8899AABB; load byte, signed, addr 0x12 → rdata 0xFFFFFF99 two cycles after acceptance; MemWr never high.
- Same word; load half, unsigned, addr 0x12 → rdata 0x00008899. Load word addr 0x10 → 0x8899AABB.
- Store byte 0x5A at addr 0x11 over 0x8899AABB → MemRd for 1 cycle, then MemWr for 1 cycle with W_data 0x88995ABB; ack 3 cycles after acceptance.
- Store word 0xDEADBEEF at addr 0x20 → one MemWr cycle, no MemRd. A subsequent word load returns 0xDEADBEEF.
- Assert rst during RMW_RD of a half store → next cycle MemRd=0, MemWr=0, busy=0, no ack; memory word unchanged.
- Misaligned load word at 0x13:
  - with MISALIGN_TRAP_EN → ack+err in the cycle after acceptance, no memory strobe;
  - without it → reads the word at 0x10.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Purpose : shared size codes, FSM state encoding and alignment helper for the
//           data-memory access controller and its lane aligner.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Also provides the WIDTH macro used by the datapath (32-bit, 4 byte lanes).

`ifndef WIDTH
`define WIDTH 32
`endif

package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // True when the low address bits break natural alignment for the size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose : combinational lane logic; extracts and sign/zero-extends load data
//           from a memory word, and merges store data into a read word.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; outputs follow inputs.
// Ports   : addr_lo/size/is_signed select the lanes; rd_word is the memory word,
//           st_data the right-aligned store data; ld_data/mrg_word are results.

module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [`WIDTH-1:0] rd_word,
  input  logic [`WIDTH-1:0] st_data,
  output logic [`WIDTH-1:0] ld_data,
  output logic [`WIDTH-1:0] mrg_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses ignore addr_lo[0]: lanes {2*a1+1, 2*a1}.
  assign byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = rd_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data  = rd_word;
    mrg_word = st_data;
    case (size)
      SZ_BYTE: begin
        ld_data  = {{(`WIDTH-8){is_signed & byte_sel[7]}}, byte_sel};
        mrg_word = rd_word;
        mrg_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
      end
      SZ_HALF: begin
        ld_data  = {{(`WIDTH-16){is_signed & half_sel[15]}}, half_sel};
        mrg_word = rd_word;
        mrg_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: begin
        ld_data  = rd_word;
        mrg_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose : initiator-side load/store controller for a word-wide little-endian
//           memory; sub-word stores use read-modify-write.
// Latency : accept->ack 2 cycles (load, word store), 3 cycles (sub-word store).
// Backpr. : one request at a time; req is ignored while busy, nothing queues.
// Ports   : req/req_* request in; busy/ack/rdata/err status out;
//           MemRd/MemWr/Addr/W_data/R_data memory port (R_data combinational).
// Option  : MISALIGN_TRAP_EN -- misaligned half/word accesses complete at once
//           with ack+err and no memory strobe; otherwise they are aligned down.

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = `WIDTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              MemRd,
  output logic              MemWr,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] W_data,
  input  logic [DATA_W-1:0] R_data
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        size_n;
  logic              trap_hit;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] mrg_word;

  // Size code 11 behaves exactly like a word access.
  assign size_n = (req_size == 2'b11) ? SZ_WORD : req_size;

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign trap_hit = is_misaligned(size_n, req_addr[1:0]);
  assign err      = (state == ST_DONE) && err_q;
`else
  assign trap_hit = 1'b0;
  assign err      = 1'b0;
`endif

  mem_lane_align u_align (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .is_signed (sgn_q),
    .rd_word   (R_data),
    .st_data   (wdata_q),
    .ld_data   (ld_data),
    .mrg_word  (mrg_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if ((state == ST_IDLE) && req) begin
        addr_q  <= req_addr;
        size_q  <= size_n;
        sgn_q   <= req_signed;
        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        err_q   <= trap_hit;
`endif
      end
      if (state == ST_RD)     rdata_q <= ld_data;
      if (state == ST_RMW_RD) merge_q <= mrg_word;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (trap_hit)              state_nx = ST_DONE;
          else if (!req_we)          state_nx = ST_RD;
          else if (size_n == SZ_WORD) state_nx = ST_WR;
          else                       state_nx = ST_RMW_RD;
        end
      end
      ST_RD:     state_nx = ST_DONE;
      ST_RMW_RD: state_nx = ST_WR;
      ST_WR:     state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so a reset edge drops them next cycle.
  assign MemRd  = (state == ST_RD) || (state == ST_RMW_RD);
  assign MemWr  = (state == ST_WR);
  assign busy   = (state == ST_RD) || (state == ST_RMW_RD) || (state == ST_WR);
  assign ack    = (state == ST_DONE);
  assign Addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign W_data = !MemWr ? '0 : ((size_q == SZ_WORD) ? wdata_q : merge_q);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : self-checking bench for mem_access_ctrl with a word-wide memory model.
// Latency : n/a.
// Backpr. : n/a.

`timescale 1ns/1ps

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, ack, err, MemRd, MemWr;
  logic [31:0] rdata, Addr, W_data, R_data;

  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err), .MemRd(MemRd),
    .MemWr(MemWr), .Addr(Addr), .W_data(W_data), .R_data(R_data)
  );

  assign R_data = mem[Addr[7:2]];
  always @(posedge clk) if (MemWr) mem[Addr[7:2]] <= W_data;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic [31:0] exp_wdata,
                     input int lat, input int rd, input int wr, input logic e);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_wdata = exp_wdata;
    v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr; v.exp_err = e;
    vq.push_back(v);
  endtask

  // Issue one request and watch until ack (bounded); counts strobes and
  // flags overlap or wrong busy in 'bad'.
  task automatic do_req(input vec_t v, output int lat, output int rdc, output int wrc,
                        output int bad, output logic [31:0] wd, output logic er);
    lat = 0; rdc = 0; wrc = 0; bad = 0; wd = '0; er = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (MemRd) rdc++;
      if (MemWr) begin wrc++; wd = W_data; end
      if (MemRd && MemWr) bad++;
      if (ack) begin
        lat = n; er = err;
        if (busy) bad++;
        break;
      end else if (!busy) bad++;
    end
  endtask

  initial begin
    int lat, rdc, wrc, bad, ackc, wrc2;
    logic [31:0] wd;
    logic er;
    logic trap;
`ifdef MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'h8899AABB;
    mem[32'h30 >> 2] = 32'hCAFEF00D;

    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;

    //  we size  sgn addr      wdata         exp_rdata     exp_wdata    lat rd wr err
    add(0, 2'b00, 1, 32'h12, 32'h0,        32'hFFFFFF99, 32'h0,        2, 1, 0, 0);
    add(0, 2'b01, 0, 32'h12, 32'h0,        32'h00008899, 32'h0,        2, 1, 0, 0);
    add(0, 2'b10, 0, 32'h10, 32'h0,        32'h8899AABB, 32'h0,        2, 1, 0, 0);
    add(0, 2'b00, 0, 32'h13, 32'h0,        32'h00000088, 32'h0,        2, 1, 0, 0);
    add(0, 2'b01, 1, 32'h10, 32'h0,        32'hFFFFAABB, 32'h0,        2, 1, 0, 0);
    add(1, 2'b00, 0, 32'h11, 32'h0000005A, 32'h0,        32'h88995ABB, 3, 1, 1, 0);
    add(0, 2'b10, 0, 32'h10, 32'h0,        32'h88995ABB, 32'h0,        2, 1, 0, 0);
    add(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2, 0, 1, 0);
    add(0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h0,        2, 1, 0, 0);
    add(1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'h0,        32'h1234BEEF, 3, 1, 1, 0);
    add(0, 2'b00, 1, 32'h23, 32'h0,        32'h00000012, 32'h0,        2, 1, 0, 0);
    if (trap) begin
      add(0, 2'b10, 0, 32'h13, 32'h0,      32'h00000012, 32'h0,        1, 0, 0, 1);
      add(0, 2'b01, 0, 32'h11, 32'h0,      32'h00000012, 32'h0,        1, 0, 0, 1);
    end else begin
      add(0, 2'b10, 0, 32'h13, 32'h0,      32'h88995ABB, 32'h0,        2, 1, 0, 0);
      add(0, 2'b01, 0, 32'h11, 32'h0,      32'h00005ABB, 32'h0,        2, 1, 0, 0);
    end
    add(0, 2'b11, 0, 32'h10, 32'h0,        32'h88995ABB, 32'h0,        2, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_memrd", {31'b0, MemRd}, 32'h0);
    chk("rst_memwr", {31'b0, MemWr}, 32'h0);
    chk("rst_addr", Addr, 32'h0);
    chk("rst_wdata", W_data, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vq[i]) begin
      do_req(vq[i], lat, rdc, wrc, bad, wd, er);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vq[i].exp_lat));
      chk($sformatf("v%0d_memrd_cycles", i), 32'(rdc), 32'(vq[i].exp_rd));
      chk($sformatf("v%0d_memwr_cycles", i), 32'(wrc), 32'(vq[i].exp_wr));
      chk($sformatf("v%0d_protocol", i), 32'(bad), 32'h0);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vq[i].exp_err});
      if (vq[i].we) chk($sformatf("v%0d_w_data", i), wd, vq[i].exp_wdata);
      else          chk($sformatf("v%0d_rdata", i), rdata, vq[i].exp_rdata);
    end

    chk("mem_0x10", mem[32'h10 >> 2], 32'h88995ABB);
    chk("mem_0x20", mem[32'h20 >> 2], 32'h1234BEEF);

    // Reset during the read phase of a half store
    @(posedge clk); #1;
    req = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h00001111;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rmw_rd_memrd", {31'b0, MemRd}, 32'h1);
    chk("rmw_rd_addr", Addr, 32'h30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_memrd", {31'b0, MemRd}, 32'h0);
    chk("midrst_memwr", {31'b0, MemWr}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_ack", {31'b0, ack}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    ackc = 0; wrc2 = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ack) ackc++;
      if (MemWr) wrc2++;
    end
    chk("midrst_no_ack", 32'(ackc), 32'h0);
    chk("midrst_no_write", 32'(wrc2), 32'h0);
    chk("midrst_mem_0x30", mem[32'h30 >> 2], 32'hCAFEF00D);

    // A fresh request after the mid-operation reset works normally
    begin
      vec_t v;
      v.we = 1'b0; v.size = 2'b00; v.sgn = 1'b1; v.addr = 32'h31; v.wdata = '0;
      v.exp_rdata = 32'hFFFFFFF0; v.exp_wdata = '0;
      v.exp_lat = 2; v.exp_rd = 1; v.exp_wr = 0; v.exp_err = 1'b0;
      do_req(v, lat, rdc, wrc, bad, wd, er);
      chk("post_rst_latency", 32'(lat), 32'h2);
      chk("post_rst_rdata", rdata, v.exp_rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
